instr_fetch_queue: RTL and testbench
====================================

INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 SHALL have parameter PC_W, default 8, instruction address width in words.
REQ-002 SHALL have parameter DEPTH, default 4, instruction queue entries (power of two, >=2).
REQ-003 SHALL have parameter START_PC, default 0, first fetch address after start.
REQ-004 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-006 SHALL have port start  input  1  one-cycle pulse; begins fetching from START_PC when IDLE.
REQ-007 SHALL have port imem_req  output  1  instruction memory read request this cycle.
REQ-008 SHALL have port imem_addr  output  PC_W  word address of the request.
REQ-009 SHALL have port imem_rdata  input  32  read data, valid exactly one cycle after imem_req.
REQ-010 SHALL have port instr_valid  output  1  queue head holds an instruction.
REQ-011 SHALL have port instr_ready  input  1  downstream decode accepts the head.
REQ-012 SHALL have port instr_out  output  32  head instruction word.
REQ-013 SHALL have port instr_pc  output  PC_W  address the head was fetched from.
REQ-014 SHALL have port redirect_valid  input  1  flush and refetch request.
REQ-015 SHALL have port redirect_pc  input  PC_W  new fetch address.
REQ-016 SHALL have port busy  output  1  high in RUN state.
REQ-017 SHALL have port halted  output  1  high in HALTED state.

Function
REQ-018 SHALL implement states IDLE, RUN and HALTED: IDLE->RUN on start; RUN->HALTED when a HALT word (bits[15:12]=4'b1111) is enqueued; any state->RUN on redirect_valid.
REQ-019 SHALL issue imem_req in RUN only when (queue count + in-flight responses) < DEPTH, then increment fetch PC by 1.
REQ-020 SHALL wrap fetch PC from 2^PC_W-1 to 0.
REQ-021 SHALL enqueue each non-squashed response, with its PC, the cycle imem_rdata is valid.
REQ-022 SHALL present head with zero extra latency: instruction fetched at cycle t is on instr_out at t+2 when queue was empty.
REQ-023 SHALL pop the head on instr_valid && instr_ready; simultaneous push and pop leaves count unchanged.
REQ-024 SHALL keep instr_out/instr_pc stable while instr_valid && !instr_ready.
REQ-025 SHALL on redirect_valid: empty the queue, squash any in-flight response, set fetch PC to redirect_pc, enter RUN; redirect overrides same-cycle push, pop and start.
REQ-026 SHALL issue no request in the redirect cycle; first fetch of redirect_pc in the following cycle.
REQ-027 SHALL discard any response arriving after a HALT word has been enqueued.
REQ-028 SHALL ignore start outside IDLE.
REQ-029 SHALL keep draining queued instructions to decode in HALTED.

Reset
REQ-030 SHALL on reset low immediately force: state IDLE, queue empty, in-flight cleared, fetch PC START_PC, imem_req 0, imem_addr 0, instr_valid 0, instr_out 0, instr_pc 0, busy 0, halted 0.
REQ-031 SHALL discard a response returning in the first cycle after reset release.

Structure
REQ-032 SHALL take INSTR_W, PC_W default, opcode enum (incl. OP_LW 0110, OP_SW 0111, OP_HALT 1111) and fetch state enum from shared package gpu_pkg.
REQ-033 SHALL instantiate one sub-module instr_fifo (synchronous FIFO, width 32+PC_W, depth DEPTH, flush input).

Verification
REQ-034 Bench SHALL check: start, imem holds ADD/SUB/MUL then HALT at 3, instr_ready=1 -> PCs 0,1,2,3 delivered in order, halted=1, no request to address 5.
REQ-035 Bench SHALL check: instr_ready=0 for 10 cycles -> exactly 4 entries, imem_req low, head stays PC 0; then ready=1 -> PCs 0..7 contiguous, no loss/duplication.
REQ-036 Bench SHALL check: redirect_valid with redirect_pc=0x20 while 3 queued + 1 in flight -> instr_valid 0 next cycle, next delivered PC 0x20.
REQ-037 Bench SHALL check: start with START_PC=0xFE, PC_W=8 -> delivered PCs 0xFE, 0xFF, 0x00.
REQ-038 Bench SHALL check: reset low mid-RUN with 2 queued -> all outputs at reset values same cycle; start after release refetches from START_PC.
REQ-039 Bench SHALL check: redirect_valid while HALTED -> RUN, halted 0, fetch resumes at redirect_pc.

Source files
------------

// File: rtl/gpu_pkg.sv
// Shared GPU front-end types: instruction/address widths, opcodes and fetch states.
// The opcode field sits in bits [15:12] of every instruction word.
package gpu_pkg;
  localparam int INSTR_W  = 32;
  localparam int PC_W_DEF = 8;

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000,
    OP_SUB  = 4'b0001,
    OP_MUL  = 4'b0010,
    OP_AND  = 4'b0011,
    OP_OR   = 4'b0100,
    OP_XOR  = 4'b0101,
    OP_LW   = 4'b0110,
    OP_SW   = 4'b0111,
    OP_BR   = 4'b1000,
    OP_HALT = 4'b1111
  } opcode_t;

  typedef enum logic [1:0] {
    FS_IDLE   = 2'd0,
    FS_RUN    = 2'd1,
    FS_HALTED = 2'd2
  } fetch_state_t;

  function automatic logic is_halt(input logic [3:0] op);
    return op == OP_HALT;
  endfunction
endpackage

// File: rtl/instr_fetch_queue_if.sv
// Fetch-queue signal bundle: instruction memory port, decode handshake, redirect and status.
interface instr_fetch_queue_if
  import gpu_pkg::*;
#(
  parameter int PC_W = PC_W_DEF
);
  logic               start;
  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               instr_valid;
  logic               instr_ready;
  logic [INSTR_W-1:0] instr_out;
  logic [PC_W-1:0]    instr_pc;
  logic               redirect_valid;
  logic [PC_W-1:0]    redirect_pc;
  logic               busy;
  logic               halted;

  modport master (
    input  start, imem_rdata, instr_ready, redirect_valid, redirect_pc,
    output imem_req, imem_addr, instr_valid, instr_out, instr_pc, busy, halted
  );
  modport slave (
    output start, imem_rdata, instr_ready, redirect_valid, redirect_pc,
    input  imem_req, imem_addr, instr_valid, instr_out, instr_pc, busy, halted
  );
endinterface

// File: rtl/instr_fifo.sv
// Synchronous FIFO with show-ahead head (dout is the current head, no read latency)
// and a flush that empties it in one cycle. DEPTH must be a power of two.
module instr_fifo #(
  parameter int W     = 40,
  parameter int DEPTH = 4
)(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  logic [W-1:0]           din,
  input  logic                   pop,
  output logic [W-1:0]           dout,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign do_push = push && (cnt_q != DEPTH_C);
  assign do_pop  = pop && (cnt_q != '0);

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + AW'(1);
      if (do_pop)  rd_d = rd_q + AW'(1);
      cnt_d = cnt_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage carries no reset; emptiness is tracked solely by cnt_q.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_q] <= din;
  end

  assign dout  = mem_q[rd_q];
  assign empty = (cnt_q == '0);
  assign count = cnt_q;
endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetch unit: issues one-cycle-latency imem reads into a small queue,
// stops at a HALT word and restarts on redirect, which flushes everything in flight.
module instr_fetch_queue
  import gpu_pkg::*;
#(
  parameter int              PC_W     = PC_W_DEF,
  parameter int              DEPTH    = 4,
  parameter logic [PC_W-1:0] START_PC = '0
)(
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr_out,
  output logic [PC_W-1:0]    instr_pc,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               busy,
  output logic               halted
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = INSTR_W + PC_W;
  localparam logic [CW:0] DEPTH_L = (CW+1)'(DEPTH);

  fetch_state_t    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d, rsp_pc_q, rsp_pc_d;
  logic            inflight_q, inflight_d;
  logic            req, push, pop, empty;
  logic [CW-1:0]   count;
  logic [CW:0]     occ;
  logic [EW-1:0]   head;

  instr_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .flush (redirect_valid),
    .push  (push),
    .din   ({rsp_pc_q, imem_rdata}),
    .pop   (pop),
    .dout  (head),
    .empty (empty),
    .count (count)
  );

  // Credit check counts the outstanding response so the queue can never overflow.
  assign occ  = {1'b0, count} + {{CW{1'b0}}, inflight_q};
  assign req  = (state_q == FS_RUN) && !redirect_valid && (occ < DEPTH_L);
  // Only RUN accepts responses: post-HALT and post-reset returns are dropped.
  assign push = inflight_q && (state_q == FS_RUN) && !redirect_valid;
  assign pop  = !empty && instr_ready && !redirect_valid;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inflight_d = req;
    rsp_pc_d   = pc_q;
    if (redirect_valid) begin
      state_d = FS_RUN;
      pc_d    = redirect_pc;
    end else begin
      if (state_q == FS_IDLE && start) begin
        state_d = FS_RUN;
        pc_d    = START_PC;
      end
      if (req) pc_d = pc_q + PC_W'(1);
      if (push && is_halt(imem_rdata[15:12])) state_d = FS_HALTED;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= FS_IDLE;
      pc_q       <= START_PC;
      inflight_q <= 1'b0;
      rsp_pc_q   <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      rsp_pc_q   <= rsp_pc_d;
    end
  end

  assign imem_req    = req;
  assign imem_addr   = req ? pc_q : '0;
  assign instr_valid = !empty;
  assign instr_out   = empty ? '0 : head[INSTR_W-1:0];
  assign instr_pc    = empty ? '0 : head[EW-1:INSTR_W];
  assign busy        = (state_q == FS_RUN);
  assign halted      = (state_q == FS_HALTED);
endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: directed scenarios plus randomized redirect/ready traffic,
// with a scoreboard that expects a contiguous PC stream ending at each HALT.
`timescale 1ns/1ps
module tb_instr_fetch_queue;
  import gpu_pkg::*;
  localparam int PCW   = 8;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  instr_fetch_queue_if #(.PC_W(PCW)) fq0();
  instr_fetch_queue_if #(.PC_W(PCW)) fq1();

  instr_fetch_queue #(.PC_W(PCW), .DEPTH(DEPTH), .START_PC(8'h00)) dut0 (
    .clk(clk), .reset(rst_n), .start(fq0.start),
    .imem_req(fq0.imem_req), .imem_addr(fq0.imem_addr), .imem_rdata(fq0.imem_rdata),
    .instr_valid(fq0.instr_valid), .instr_ready(fq0.instr_ready),
    .instr_out(fq0.instr_out), .instr_pc(fq0.instr_pc),
    .redirect_valid(fq0.redirect_valid), .redirect_pc(fq0.redirect_pc),
    .busy(fq0.busy), .halted(fq0.halted)
  );

  instr_fetch_queue #(.PC_W(PCW), .DEPTH(DEPTH), .START_PC(8'hFE)) dut1 (
    .clk(clk), .reset(rst_n), .start(fq1.start),
    .imem_req(fq1.imem_req), .imem_addr(fq1.imem_addr), .imem_rdata(fq1.imem_rdata),
    .instr_valid(fq1.instr_valid), .instr_ready(fq1.instr_ready),
    .instr_out(fq1.instr_out), .instr_pc(fq1.instr_pc),
    .redirect_valid(fq1.redirect_valid), .redirect_pc(fq1.redirect_pc),
    .busy(fq1.busy), .halted(fq1.halted)
  );

  logic [31:0] mem [256];

  // Instruction memory: data returns exactly one cycle after the request.
  always @(posedge clk) begin
    fq0.imem_rdata <= fq0.imem_req ? mem[fq0.imem_addr] : 32'hDEAD_BEEF;
    fq1.imem_rdata <= fq1.imem_req ? mem[fq1.imem_addr] : 32'hDEAD_BEEF;
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%h exp=%h", tag, act, exp);
    end
  endtask

  // Reference model: expected next PC, idle (awaiting start) and stopped-after-HALT flags.
  logic [PCW-1:0] exp_pc = '0;
  bit             m_idle = 1'b1;
  bit             m_stop = 1'b0;
  int             n_deliv = 0;
  logic [PCW-1:0] got0[$];
  logic [PCW-1:0] req0[$];
  logic [PCW-1:0] got1[$];

  always @(negedge clk) begin
    if (!rst_n) begin
      m_idle = 1'b1;
      m_stop = 1'b0;
    end else if (fq0.redirect_valid) begin
      exp_pc = fq0.redirect_pc;
      m_idle = 1'b0;
      m_stop = 1'b0;
    end else begin
      if (fq0.start && m_idle) begin
        m_idle = 1'b0;
        exp_pc = 8'h00;
      end
      if (fq0.instr_valid && fq0.instr_ready) begin
        got0.push_back(fq0.instr_pc);
        n_deliv++;
        chk("deliv_allowed", {31'b0, m_idle | m_stop}, 32'd0);
        if (!m_idle && !m_stop) begin
          chk("deliv_pc", {24'b0, fq0.instr_pc}, {24'b0, exp_pc});
          chk("deliv_instr", fq0.instr_out, mem[fq0.instr_pc]);
          if (fq0.instr_out[15:12] == 4'hF) m_stop = 1'b1;
          exp_pc = exp_pc + 8'd1;
        end
      end
      if (fq0.imem_req) req0.push_back(fq0.imem_addr);
    end
    if (rst_n && fq1.instr_valid && fq1.instr_ready) got1.push_back(fq1.instr_pc);
  end

  function automatic logic [31:0] mkw(input logic [3:0] op, input logic [7:0] k);
    return {8'hA5, k, op, 4'h3, k};
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_deliv(input int n, input int lim);
    int c = 0;
    while (got0.size() < n && c < lim) begin
      tick();
      c++;
    end
    if (got0.size() < n) chk("deliv_timeout", got0.size(), n);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_req"},    {31'b0, fq0.imem_req}, 32'd0);
    chk({tag, "_addr"},   {24'b0, fq0.imem_addr}, 32'd0);
    chk({tag, "_valid"},  {31'b0, fq0.instr_valid}, 32'd0);
    chk({tag, "_out"},    fq0.instr_out, 32'd0);
    chk({tag, "_pc"},     {24'b0, fq0.instr_pc}, 32'd0);
    chk({tag, "_busy"},   {31'b0, fq0.busy}, 32'd0);
    chk({tag, "_halted"}, {31'b0, fq0.halted}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int hit5;
    int d0;
    logic [31:0] w;
    fq0.start = 0; fq0.instr_ready = 0; fq0.redirect_valid = 0; fq0.redirect_pc = '0;
    fq1.start = 0; fq1.instr_ready = 0; fq1.redirect_valid = 0; fq1.redirect_pc = '0;
    for (int i = 0; i < 256; i++) mem[i] = mkw(OP_ADD, 8'(i));

    // Reset state
    #1 rst_n = 1'b0;
    #3 chk_reset_outs("rst");
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    tick();

    // ADD/SUB/MUL then HALT at 3
    mem[0] = mkw(OP_ADD, 8'd0); mem[1] = mkw(OP_SUB, 8'd1);
    mem[2] = mkw(OP_MUL, 8'd2); mem[3] = mkw(OP_HALT, 8'd3);
    got0.delete(); req0.delete();
    fq0.instr_ready = 1'b1; fq0.start = 1'b1;
    tick();
    fq0.start = 1'b0;
    tick(15);
    chk("t1_count", got0.size(), 4);
    for (int i = 0; i < 4 && i < got0.size(); i++) chk("t1_pc", {24'b0, got0[i]}, i);
    chk("t1_halted", {31'b0, fq0.halted}, 32'd1);
    chk("t1_busy", {31'b0, fq0.busy}, 32'd0);
    hit5 = 0;
    foreach (req0[i]) if (req0[i] == 8'd5) hit5++;
    chk("t1_no_req5", hit5, 0);

    // Redirect out of HALTED
    mem[3] = mkw(OP_LW, 8'd3);
    fq0.redirect_pc = 8'h40; fq0.redirect_valid = 1'b1;
    @(negedge clk);
    chk("rd_noreq", {31'b0, fq0.imem_req}, 32'd0);
    @(posedge clk); #1;
    fq0.redirect_valid = 1'b0;
    @(negedge clk);
    chk("rd_halted", {31'b0, fq0.halted}, 32'd0);
    chk("rd_busy", {31'b0, fq0.busy}, 32'd1);
    chk("rd_req", {31'b0, fq0.imem_req}, 32'd1);
    chk("rd_addr", {24'b0, fq0.imem_addr}, 32'h40);
    @(posedge clk); #1;

    // Back-pressure: queue fills to DEPTH and holds the head
    fq0.instr_ready = 1'b0; fq0.redirect_pc = 8'h00; fq0.redirect_valid = 1'b1;
    got0.delete(); req0.delete();
    tick();
    fq0.redirect_valid = 1'b0;
    tick(10);
    chk("t2_nreq", req0.size(), DEPTH);
    chk("t2_req", {31'b0, fq0.imem_req}, 32'd0);
    chk("t2_valid", {31'b0, fq0.instr_valid}, 32'd1);
    chk("t2_head", {24'b0, fq0.instr_pc}, 32'd0);
    fq0.instr_ready = 1'b1;
    wait_deliv(8, 40);
    for (int i = 0; i < 8 && i < got0.size(); i++) chk("t2_pc", {24'b0, got0[i]}, i);

    // Redirect with 3 queued + 1 in flight
    fq0.instr_ready = 1'b0; fq0.redirect_pc = 8'h10; fq0.redirect_valid = 1'b1;
    tick();
    fq0.redirect_valid = 1'b0;
    tick(4);
    chk("t3_full_req", {31'b0, fq0.imem_req}, 32'd0);
    chk("t3_full_valid", {31'b0, fq0.instr_valid}, 32'd1);
    fq0.redirect_pc = 8'h20; fq0.redirect_valid = 1'b1;
    got0.delete();
    tick();
    fq0.redirect_valid = 1'b0;
    chk("t3_flushed", {31'b0, fq0.instr_valid}, 32'd0);
    fq0.instr_ready = 1'b1;
    wait_deliv(1, 20);
    if (got0.size() > 0) chk("t3_pc", {24'b0, got0[0]}, 32'h20);

    // PC wrap on the START_PC=0xFE instance
    fq1.instr_ready = 1'b1; fq1.start = 1'b1;
    tick();
    fq1.start = 1'b0;
    tick(12);
    chk("t4_count", {31'b0, got1.size() >= 3}, 32'd1);
    if (got1.size() >= 3) begin
      chk("t4_pc0", {24'b0, got1[0]}, 32'hFE);
      chk("t4_pc1", {24'b0, got1[1]}, 32'hFF);
      chk("t4_pc2", {24'b0, got1[2]}, 32'h00);
    end

    // Reset mid-RUN with 2 queued
    fq0.instr_ready = 1'b0; fq0.redirect_pc = 8'h00; fq0.redirect_valid = 1'b1;
    tick();
    fq0.redirect_valid = 1'b0;
    tick(3);
    chk("t5_pre_valid", {31'b0, fq0.instr_valid}, 32'd1);
    rst_n = 1'b0;
    #1 chk_reset_outs("t5");
    tick();
    rst_n = 1'b1;
    tick(3);
    chk("t5_idle_valid", {31'b0, fq0.instr_valid}, 32'd0);
    chk("t5_idle_busy", {31'b0, fq0.busy}, 32'd0);
    got0.delete();
    fq0.instr_ready = 1'b1; fq0.start = 1'b1;
    tick();
    fq0.start = 1'b0;
    wait_deliv(1, 20);
    if (got0.size() > 0) chk("t5_pc", {24'b0, got0[0]}, 32'h00);

    // Randomized traffic: occasional HALTs, random redirects and ready
    d0 = n_deliv;
    for (int c = 0; c < 1000; c++) begin
      if (c == 0 || $urandom_range(0, 39) == 0) begin
        if (c == 0) begin
          for (int i = 0; i < 256; i++) begin
            w = $urandom;
            if ($urandom_range(0, 15) == 0) w[15:12] = 4'hF;
            else if (w[15:12] == 4'hF) w[15:12] = 4'h0;
            mem[i] = w;
          end
        end
        fq0.redirect_valid = 1'b1;
        fq0.redirect_pc = 8'($urandom);
      end else begin
        fq0.redirect_valid = 1'b0;
      end
      fq0.instr_ready = ($urandom_range(0, 9) < 6);
      fq0.start = ($urandom_range(0, 49) == 0);
      tick();
    end
    fq0.redirect_valid = 1'b0; fq0.start = 1'b0; fq0.instr_ready = 1'b1;
    tick(10);
    chk("rnd_activity", {31'b0, (n_deliv - d0) > 50}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
